// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage: instruction-fetch stage and IF/ID pipeline register for the 16-bit
// MIPS16-style pipeline. It issues fetch requests to instruction memory and
// presents the fetched instruction (inst_o) and its address + 1 (pc_o) to the
// decode stage. It takes decode's stall and taken-branch redirect and
// implements one architectural delay slot. It inserts NOP bubbles while no
// instruction is available.
//
// Optional feature macro: IFETCH_HOLD_BUF_EN
//   defined   : an instruction acked during a stall is parked in a one-entry
//               buffer (HOLD state) and never refetched.
//   undefined : such an ack is dropped and the same pc is re-requested until
//               it is acked with stall_i=0.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall_i          hold the IF/ID register
//   branch_flag_i    taken branch in decode (combinational)
//   branch_addr_i    branch target
//   imem_req_o       fetch request
//   imem_addr_o      fetch address (internal pc)
//   imem_ack_i       imem_rdata_i valid this cycle
//   imem_rdata_i     fetched instruction
//   pc_o             IF/ID: address of held instruction + 1
//   inst_o           IF/ID: instruction presented to decode
// -----------------------------------------------------------------------------
module if_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [15:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [15:0] imem_rdata_i,
   output logic [15:0] pc_o,
   output logic [15:0] inst_o
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic [15:0] pc_reg, pc_next;
   logic        redir_pend_reg, redir_pend_next;
   logic [15:0] redir_addr_reg, redir_addr_next;
   logic [15:0] if_pc_reg, if_pc_next;
   logic [15:0] if_inst_reg, if_inst_next;
   logic        accept;
   logic [15:0] accept_inst;
`ifdef IFETCH_HOLD_BUF_EN
   logic [15:0] buf_inst_reg, buf_inst_next;
`endif

   assign imem_req_o  = (state_reg == FETCH) & ~rst;
   assign imem_addr_o = pc_reg;
   assign pc_o        = if_pc_reg;
   assign inst_o      = if_inst_reg;

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      redir_pend_next = redir_pend_reg;
      redir_addr_next = redir_addr_reg;
      if_pc_next      = if_pc_reg;
      if_inst_next    = if_inst_reg;
      accept          = 1'b0;
      accept_inst     = imem_rdata_i;
`ifdef IFETCH_HOLD_BUF_EN
      buf_inst_next   = buf_inst_reg;
      if (state_reg == HOLD) begin
         // No request is outstanding here, so any ack is ignored.
         if (!stall_i) begin
            accept      = 1'b1;
            accept_inst = buf_inst_reg;
            state_next  = FETCH;
         end
      end else if (imem_ack_i) begin
         if (!stall_i) begin
            accept = 1'b1;
         end else begin
            // Park the instruction so the fetch is not repeated.
            buf_inst_next = imem_rdata_i;
            state_next    = HOLD;
         end
      end
`else
      // An ack during a stall is simply dropped; pc is unchanged, so the
      // same address is requested again.
      accept = imem_ack_i & ~stall_i;
`endif

      if (accept) begin
         if_inst_next    = accept_inst;
         if_pc_next      = pc_reg + 16'd1;
         redir_pend_next = 1'b0;
         // A same-cycle branch makes the accepted instruction the delay slot;
         // otherwise a redirect remembered earlier takes effect now.
         if (branch_flag_i)
            pc_next = branch_addr_i;
         else if (redir_pend_reg)
            pc_next = redir_addr_reg;
         else
            pc_next = pc_reg + 16'd1;
      end else if (!stall_i) begin
         // No instruction to hand over: issue a bubble, keep pc_o.
         if_inst_next = NOP_INST;
         if (branch_flag_i) begin
            // The delay slot has not arrived yet; redirect after it.
            redir_pend_next = 1'b1;
            redir_addr_next = branch_addr_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= FETCH;
         pc_reg         <= RESET_PC;
         redir_pend_reg <= 1'b0;
         redir_addr_reg <= 16'h0000;
         if_pc_reg      <= 16'h0000;
         if_inst_reg    <= NOP_INST;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         redir_pend_reg <= redir_pend_next;
         redir_addr_reg <= redir_addr_next;
         if_pc_reg      <= if_pc_next;
         if_inst_reg    <= if_inst_next;
      end
   end

`ifdef IFETCH_HOLD_BUF_EN
   always_ff @(posedge clk) begin
      if (rst)
         buf_inst_reg <= NOP_INST;
      else
         buf_inst_reg <= buf_inst_next;
   end
`endif

endmodule
